// File: rtl/pixel_alu_unit_if.sv
// pixel_alu_unit_if: instruction stream, pixel inputs and colour output of one ALU lane.
interface pixel_alu_unit_if #(
  parameter int INSTRUCTION_WIDTH = 46,
  parameter int DATA_WIDTH        = 32,
  parameter int OUTPUT_WIDTH      = 12
);
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic [DATA_WIDTH-1:0]        x_coord;
  logic [DATA_WIDTH-1:0]        y_coord;
  logic [DATA_WIDTH-1:0]        f_number;
  logic [OUTPUT_WIDTH-1:0]      output_value;
  modport master (output instruction, x_coord, y_coord, f_number, input output_value);
  modport slave  (input instruction, x_coord, y_coord, f_number, output output_value);
endinterface

// File: rtl/pixel_alu_unit.sv
// pixel_alu_unit: single-issue per-pixel ALU with five private registers and a registered colour output.
module pixel_alu_unit #(
  parameter int INSTRUCTION_WIDTH = 46,
  parameter int DATA_WIDTH        = 32,
  parameter int OUTPUT_WIDTH      = 12
) (
  input logic             clk,
  input logic             reset_n,
  pixel_alu_unit_if.slave bus
);
  logic [INSTRUCTION_WIDTH-1:0] ins;
  logic [3:0]                   op;
  logic [2:0]                   dest, sel_a, sel_b;
  logic                         use_imm, wr;
  logic [DATA_WIDTH-1:0]        imm, a, b, res;
  logic [4:0]                   sh;
  logic [DATA_WIDTH-1:0]        opnd [8];
  logic [DATA_WIDTH-1:0]        regs_q [5];
  logic [OUTPUT_WIDTH-1:0]      out_q;
  assign ins = bus.instruction;
  assign {op, dest, sel_a, sel_b, use_imm, imm} = ins;
  always_comb begin
    for (int k = 0; k < 5; k++) opnd[k] = regs_q[k];
    opnd[5] = bus.x_coord;
    opnd[6] = bus.y_coord;
    opnd[7] = bus.f_number;
  end
  assign a  = opnd[sel_a];
  assign b  = use_imm ? imm : opnd[sel_b];
  assign sh = b[4:0];
  // opcodes 0 and 15 never write, so zeroed instruction memory is inert
  assign wr = (op != 4'd0) && (op != 4'd15);
  always_comb begin
    res = '0;
    case (op)
      4'd1:  res = a + b;
      4'd2:  res = a - b;
      4'd3:  res = a & b;
      4'd4:  res = a | b;
      4'd5:  res = a ^ b;
      4'd6:  res = a << sh;
      4'd7:  res = a >> sh;
      4'd8:  res = $signed(a) >>> sh;
      4'd9:  res = a * b;
      4'd10: res = b;
      4'd11: res = DATA_WIDTH'($signed(a) < $signed(b));
      4'd12: res = DATA_WIDTH'(a == b);
      4'd13: res = ($signed(a) < $signed(b)) ? a : b;
      4'd14: res = ($signed(a) < $signed(b)) ? b : a;
      default: res = '0;
    endcase
  end
  // dest 5/6 name read-only inputs, so writes there fall through untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 5; k++) regs_q[k] <= '0;
      out_q <= '0;
    end else begin
      for (int k = 0; k < 5; k++) if (wr && dest == 3'(k)) regs_q[k] <= res;
      if (wr && dest == 3'd7) out_q <= res[OUTPUT_WIDTH-1:0];
    end
  end
  assign bus.output_value = out_q;
endmodule

// File: tb/tb_pixel_alu_unit.sv
// tb_pixel_alu_unit: directed programs against a behavioural lane model, checked every cycle
// plus literal colour expectations for each scenario.
module tb_pixel_alu_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_r [5];
  logic [11:0] m_out = '0;
  pixel_alu_unit_if bus ();
  pixel_alu_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [45:0] mk(input int op, input int d, input int sa, input int sb,
                                     input bit ui, input logic [31:0] imm);
    mk = {4'(op), 3'(d), 3'(sa), 3'(sb), ui, imm};
  endfunction
  function automatic logic [31:0] rd(input logic [2:0] s);
    rd = (s == 5) ? bus.x_coord : (s == 6) ? bus.y_coord : (s == 7) ? bus.f_number : m_r[s];
  endfunction
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    longint sa, sb;
    n  = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      1:  alu = a + b;
      2:  alu = a - b;
      3:  alu = a & b;
      4:  alu = a | b;
      5:  alu = a ^ b;
      6:  alu = 32'(64'(a) * (64'd1 << n));
      7:  alu = 32'(64'(a) / (64'd1 << n));
      8:  alu = 32'((sa - ((sa < 0) ? ((longint'(1) << n) - 1) : 0)) / (longint'(1) << n));
      9:  alu = 32'(64'(a) * 64'(b));
      10: alu = b;
      11: alu = (sa < sb) ? 32'd1 : 32'd0;
      12: alu = (a == b) ? 32'd1 : 32'd0;
      13: alu = (sa < sb) ? a : b;
      14: alu = (sa > sb) ? a : b;
      default: alu = '0;
    endcase
  endfunction
  task automatic step(input logic [45:0] ins);
    logic [3:0] op;
    logic [2:0] d;
    logic [31:0] r;
    bus.instruction = ins;
    op = ins[45:42];
    d  = ins[41:39];
    r  = alu(op, rd(ins[38:36]), ins[32] ? ins[31:0] : rd(ins[35:33]));
    @(posedge clk);
    #1;
    if (reset_n && op != 0 && op != 15) begin
      if (d < 5) m_r[d] = r;
      else if (d == 7) m_out = r[11:0];
    end
  endtask
  task automatic chk(input string name, input logic [11:0] exp);
    checks++;
    if (bus.output_value !== exp || m_out !== exp) begin
      errors++;
      $display("FAIL %s: dut=%h model=%h expected=%h", name, bus.output_value, m_out, exp);
    end
  endtask
  always @(negedge clk) begin
    checks++;
    if (bus.output_value !== m_out) begin
      errors++;
      $display("FAIL cycle@%0t: dut=%h model=%h", $time, bus.output_value, m_out);
    end
  end
  initial begin
    for (int i = 0; i < 5; i++) m_r[i] = '0;
    bus.instruction = '0;
    bus.x_coord = 32'd100;
    bus.y_coord = 32'd3;
    bus.f_number = 32'h0000_0ABC;
    // held in reset: ADD dest7, r0 + 5 must not land
    step(mk(1, 7, 0, 0, 1, 5));
    step(mk(1, 7, 0, 0, 1, 5));
    chk("reset_hold", 12'h000);
    reset_n = 1'b1;
    step(mk(1, 7, 0, 0, 1, 5));
    chk("reset_release", 12'h005);
    step(mk(10, 0, 0, 0, 1, 32'h1234_5678));
    step(mk(10, 7, 0, 0, 0, 0));
    chk("mov_imm", 12'h678);
    step(mk(1, 1, 5, 6, 0, 0));
    step(mk(9, 2, 1, 0, 1, 2));
    step(mk(10, 7, 0, 2, 0, 0));
    chk("xy_mul", 12'h0CE);
    step(mk(10, 0, 0, 0, 1, 32'hFFFF_FFFF));
    step(mk(1, 0, 0, 0, 1, 1));
    step(mk(10, 7, 0, 0, 0, 0));
    chk("add_wrap", 12'h000);
    step(mk(10, 3, 0, 0, 1, 1));
    step(mk(6, 1, 3, 0, 1, 33));
    step(mk(10, 7, 0, 1, 0, 0));
    chk("shl_mod32", 12'h002);
    step(mk(10, 0, 0, 0, 1, 32'hFFFF_FFFE));
    step(mk(11, 1, 0, 0, 1, 1));
    step(mk(8, 2, 0, 0, 1, 1));
    step(mk(7, 3, 0, 0, 1, 28));
    step(mk(14, 4, 0, 0, 1, 3));
    step(mk(10, 7, 0, 1, 0, 0));
    chk("slt", 12'h001);
    step(mk(10, 7, 0, 2, 0, 0));
    chk("asr", 12'hFFF);
    step(mk(10, 7, 0, 3, 0, 0));
    chk("shr", 12'h00F);
    step(mk(10, 7, 0, 4, 0, 0));
    chk("max", 12'h003);
    step(mk(13, 7, 0, 0, 1, 3));
    chk("min", 12'hFFE);
    step(mk(12, 7, 0, 0, 1, 32'hFFFF_FFFE));
    chk("seq", 12'h001);
    step(mk(2, 7, 5, 0, 1, 1));
    chk("sub_x", 12'h063);
    step(mk(5, 7, 4, 0, 1, 32'h0FF0));
    chk("xor", 12'hFF3);
    step(mk(3, 7, 7, 0, 1, 32'h0F0F));
    chk("and_f", 12'hA0C);
    step(mk(4, 7, 1, 0, 1, 32'h0100));
    chk("or", 12'h101);
    step(mk(1, 5, 0, 0, 1, 9));
    step(mk(1, 6, 0, 0, 1, 9));
    step(mk(10, 7, 0, 5, 0, 0));
    chk("dest5_discard", 12'h064);
    step('0);
    step(mk(15, 7, 0, 0, 1, 32'h123));
    step(mk(15, 4, 0, 0, 1, 77));
    chk("nop_out", 12'h064);
    step(mk(10, 7, 0, 4, 0, 0));
    chk("nop_regs", 12'h003);
    step(mk(8, 7, 0, 0, 1, 32'h0000_0021));
    chk("asr_mod32", 12'hFFF);
    #2 reset_n = 1'b0;
    for (int i = 0; i < 5; i++) m_r[i] = '0;
    m_out = '0;
    #1;
    chk("reset_async", 12'h000);
    @(negedge clk);
    reset_n = 1'b1;
    step(mk(1, 7, 2, 0, 1, 7));
    chk("post_reset_regs", 12'h007);
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
